eight_bit_4ch_rr_arbiter: RTL and testbench
===========================================

// Module: eight_bit_4ch_rr_arbiter
// PURPOSE
//  Upstream stage of the 8-bit 4:1 output mux. Buffers one byte per channel (a..d), picks an
//  occupied channel round-robin, and drives the mux data inputs plus select lines s1:s0.
//  Presents valid/ready toward the consumer of the mux output.
//  Mapping matches the mux: s1s0 = 00 selects a, 01 selects b, 10 selects c, 11 selects d.
// PARAMETERS
//  WIDTH     8    data width per channel; must equal the mux width (8)
// PORTS
//  clk        in   1      single clock, rising edge
//  reset      in   1      asynchronous, active-high; clears all state immediately
//  in_data_a  in   WIDTH  channel 0 write data (in_data_b/c/d identical for ch 1/2/3)
//  in_valid   in   4      per-channel write request, bit i = channel i
//  in_ready   out  4      per-channel slot empty; write accepted when in_valid[i] & in_ready[i]
//  ch_a..ch_d out  WIDTH  holding-register contents, wired to mux a/b/c/d
//  s0, s1     out  1      mux select = granted channel index {s1,s0}
//  out_valid  out  1      mux output currently carries a granted byte
//  out_ready  in   1      consumer accepts mux output this cycle
// BEHAVIOUR
//  - Reset values: full[3:0]=0, ch_a..ch_d=0, sel=0 (s1=s0=0), last=3, state=IDLE,
//    out_valid=0, in_ready=4'b1111.
//  - Per channel: in_ready[i] = ~full[i] (registered flag, no same-cycle bypass). On accept,
//    data latched and full[i] set at that edge; register never changes while full[i]=1.
//  - FSM IDLE: if |full, sel <= first full channel scanning last+1, last+2, ... (mod 4);
//    go GRANT. Else stay IDLE, out_valid=0.
//  - FSM GRANT: out_valid=1 (combinational from state). On out_valid & out_ready:
//    full[sel] cleared, last <= sel, go IDLE. Without out_ready: hold sel, ch_*, out_valid.
//  - Latency: write accepted at edge N -> out_valid=1 from edge N+1 (IDLE picks at N+1).
//  - Throughput (macro off): max one grant per 2 cycles (IDLE bubble after each transfer).
//  - Simultaneous: clear of full[sel] and in_valid[sel] same cycle -> write not accepted
//    (in_ready was 0); accepted earliest next cycle. Writes to non-granted channels proceed
//    normally during GRANT and do not disturb sel.
//  - Wrap-around: scan index is 2-bit modulo; last=3 starts scan at channel 0.
//  - Reset mid-GRANT: out_valid, s1/s0, full drop asynchronously; in-flight byte is discarded.
// CONFIGURATION
//  ARB_BACK_TO_BACK_EN defined: in GRANT on handshake, if any other channel full, sel <= next
//    full channel after the current one (round-robin, excluding the cleared one), stay GRANT;
//    else go IDLE. Throughput one grant per cycle.
//  Not defined: behaviour exactly as in BEHAVIOUR (always return to IDLE).
// STRUCTURE
//  Shared package: FSM state encoding (IDLE=1'b0, GRANT=1'b1), channel index constants
//    CH_A..CH_D = 2'd0..2'd3, WIDTH default.
//  Sub-module: one_slot_buffer (WIDTH data reg + full flag, wr/clr inputs), instantiated x4.
//  Top holds FSM, sel/last registers and the round-robin next-channel function.
// TESTING
//  1 Reset release -> in_ready=4'b1111, out_valid=0, {s1,s0}=00, ch_a..ch_d=8'h00.
//  2 Write c=8'h5A at edge N, out_ready=1 -> edge N+1 {s1,s0}=10, out_valid=1, ch_c=8'h5A;
//    handshake -> in_ready[2]=1 next cycle.
//  3 Load a..d = 8'h11,22,33,44 together, out_ready=1 -> grant order a,b,c,d; spacing 2 cycles
//    (1 cycle with ARB_BACK_TO_BACK_EN).
//  4 Channel b granted, out_ready=0 for 5 cycles, new write to b -> out_valid, {s1,s0}=01 and
//    ch_b stable, in_ready[1]=0, write not taken.
//  5 After b served, a and d both full -> d granted before a (round-robin from last=1 scans c,d,a).
//  6 Assert reset while out_valid=1 mid-cycle -> out_valid=0 and full=0 before next clock edge.

Source files
------------

// File: rtl/eight_bit_4ch_rr_arbiter_pkg.sv
// Shared types and constants for the 4-channel round-robin arbiter feeding the 8-bit 4:1 mux.
// Also holds the round-robin channel pick used by the top-level FSM.
package eight_bit_4ch_rr_arbiter_pkg;

   localparam int WIDTH_DEF = 8;

   localparam logic [1:0] CH_A = 2'd0;
   localparam logic [1:0] CH_B = 2'd1;
   localparam logic [1:0] CH_C = 2'd2;
   localparam logic [1:0] CH_D = 2'd3;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_e;

   // First set bit of full[] scanning last+1, last+2, ... (mod 4).
   // Iterating downward lets the closest candidate overwrite the farther ones.
   function automatic logic [1:0] rr_next(input logic [3:0] full, input logic [1:0] last);
      logic [1:0] idx;
      rr_next = last;
      for (int k = 4; k >= 1; k--) begin
         idx = last + 2'(k);
         if (full[idx]) rr_next = idx;
      end
   endfunction

endpackage

// File: rtl/eight_bit_4ch_rr_arbiter_one_slot_buffer.sv
// One-entry holding register with a full flag.
// A write is taken only while empty; the data register is frozen while full.
module one_slot_buffer
   import eight_bit_4ch_rr_arbiter_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             wr_i,
   input  logic             clr_i,
   input  logic [WIDTH-1:0] din_i,
   output logic [WIDTH-1:0] dout_o,
   output logic             full_o
);

   logic             full_q, full_d;
   logic [WIDTH-1:0] data_q, data_d;
   logic             wr_ok;

   assign wr_ok = wr_i & ~full_q;

   always_comb begin
      full_d = full_q;
      data_d = data_q;
      if (wr_ok) begin
         full_d = 1'b1;
         data_d = din_i;
      end else if (clr_i) begin
         full_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         full_q <= 1'b0;
         data_q <= '0;
      end else begin
         full_q <= full_d;
         data_q <= data_d;
      end
   end

   assign dout_o = data_q;
   assign full_o = full_q;

endmodule

// File: rtl/eight_bit_4ch_rr_arbiter.sv
// Buffers one byte per channel a..d, grants an occupied channel round-robin and drives mux selects.
// Define ARB_BACK_TO_BACK_EN to chain grants without an IDLE bubble between transfers.
module eight_bit_4ch_rr_arbiter
   import eight_bit_4ch_rr_arbiter_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] in_data_a,
   input  logic [WIDTH-1:0] in_data_b,
   input  logic [WIDTH-1:0] in_data_c,
   input  logic [WIDTH-1:0] in_data_d,
   input  logic [3:0]       in_valid,
   output logic [3:0]       in_ready,
   output logic [WIDTH-1:0] ch_a,
   output logic [WIDTH-1:0] ch_b,
   output logic [WIDTH-1:0] ch_c,
   output logic [WIDTH-1:0] ch_d,
   output logic             s0,
   output logic             s1,
   output logic             out_valid,
   input  logic             out_ready
);

   state_e                 state_q, state_d;
   logic [1:0]             sel_q, sel_d;
   logic [1:0]             last_q, last_d;
   logic [3:0]             full, clr;
   logic [3:0][WIDTH-1:0]  din, dout;

   assign din = {in_data_d, in_data_c, in_data_b, in_data_a};

   for (genvar i = 0; i < 4; i++) begin : g_slot
      one_slot_buffer #(.WIDTH(WIDTH)) u_slot (
         .clk    (clk),
         .reset  (reset),
         .wr_i   (in_valid[i]),
         .clr_i  (clr[i]),
         .din_i  (din[i]),
         .dout_o (dout[i]),
         .full_o (full[i])
      );
   end

   always_comb begin
      state_d = state_q;
      sel_d   = sel_q;
      last_d  = last_q;
      clr     = '0;
      case (state_q)
         IDLE: begin
            if (|full) begin
               sel_d   = rr_next(full, last_q);
               state_d = GRANT;
            end
         end
         GRANT: begin
            if (out_ready) begin
               clr[sel_q] = 1'b1;
               last_d     = sel_q;
`ifdef ARB_BACK_TO_BACK_EN
               // Only slots already full at this edge are candidates; the one being served is excluded.
               if (|(full & ~clr)) sel_d = rr_next(full & ~clr, sel_q);
               else                state_d = IDLE;
`else
               state_d = IDLE;
`endif
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         sel_q   <= CH_A;
         last_q  <= CH_D;
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
         last_q  <= last_d;
      end
   end

   assign in_ready  = ~full;
   assign out_valid = (state_q == GRANT);
   assign s1        = sel_q[1];
   assign s0        = sel_q[0];
   assign ch_a      = dout[CH_A];
   assign ch_b      = dout[CH_B];
   assign ch_c      = dout[CH_C];
   assign ch_d      = dout[CH_D];

endmodule

// File: tb/tb_eight_bit_4ch_rr_arbiter.sv
// Directed bench for the 4-channel round-robin arbiter: expected grants are queued when
// writes are driven and popped by a monitor on every out_valid & out_ready handshake.
module tb_eight_bit_4ch_rr_arbiter;

`ifdef ARB_BACK_TO_BACK_EN
   localparam int SPACING = 1;
`else
   localparam int SPACING = 2;
`endif

   logic       clk, reset;
   logic [7:0] in_data_a, in_data_b, in_data_c, in_data_d;
   logic [3:0] in_valid, in_ready;
   logic [7:0] ch_a, ch_b, ch_c, ch_d;
   logic       s0, s1, out_valid, out_ready;

   eight_bit_4ch_rr_arbiter #(.WIDTH(8)) dut (
      .clk(clk), .reset(reset),
      .in_data_a(in_data_a), .in_data_b(in_data_b), .in_data_c(in_data_c), .in_data_d(in_data_d),
      .in_valid(in_valid), .in_ready(in_ready),
      .ch_a(ch_a), .ch_b(ch_b), .ch_c(ch_c), .ch_d(ch_d),
      .s0(s0), .s1(s1), .out_valid(out_valid), .out_ready(out_ready)
   );

   int   pass_cnt = 0;
   int   chk_cnt  = 0;
   int   cyc      = 0;
   logic [9:0] sb[$];   // {channel, byte}
   int   hs_cyc[$];

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      chk_cnt++;
      assert (obs === exp) pass_cnt++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   function automatic logic [7:0] mux_out();
      case ({s1, s0})
         2'd0:    return ch_a;
         2'd1:    return ch_b;
         2'd2:    return ch_c;
         default: return ch_d;
      endcase
   endfunction

   // Scoreboard monitor: every handshake must match the oldest expected grant.
   always @(negedge clk) begin
      logic [9:0] e;
      if (!reset && out_valid && out_ready) begin
         hs_cyc.push_back(cyc);
         if (sb.size() == 0) begin
            check("sb_unexpected_grant", {22'd0, s1, s0, mux_out()}, 32'h3ff);
         end else begin
            e = sb.pop_front();
            check("grant_sel", {30'd0, s1, s0}, {30'd0, e[9:8]});
            check("grant_data", {24'd0, mux_out()}, {24'd0, e[7:0]});
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
   endtask

   task automatic wait_drain(input string tag, input int maxc);
      for (int i = 0; i < maxc && sb.size() != 0; i++) tick();
      tick();
      check(tag, sb.size(), 0);
   endtask

   initial begin
      reset = 1'b1; in_valid = '0; out_ready = 1'b0;
      in_data_a = '0; in_data_b = '0; in_data_c = '0; in_data_d = '0;
      tick(); tick();
      reset = 1'b0;
      tick();

      // 1: reset state
      check("rst_in_ready", in_ready, 4'b1111);
      check("rst_out_valid", out_valid, 1'b0);
      check("rst_sel", {s1, s0}, 2'b00);
      check("rst_ch", {ch_a, ch_b, ch_c, ch_d}, 32'h0);

      // 2: single write to c
      in_data_c = 8'h5A; in_valid = 4'b0100; out_ready = 1'b1;
      sb.push_back({2'd2, 8'h5A});
      tick();
      in_valid = '0;
      check("c_in_ready_full", in_ready, 4'b1011);
      check("c_out_valid_lat", out_valid, 1'b0);
      tick();
      check("c_sel", {s1, s0}, 2'b10);
      check("c_out_valid", out_valid, 1'b1);
      check("c_ch_c", ch_c, 8'h5A);
      tick();
      check("c_in_ready_freed", in_ready, 4'b1111);
      check("c_sb_empty", sb.size(), 0);

      // 3: all four loaded together from reset (last=3) -> a,b,c,d
      do_reset();
      hs_cyc.delete();
      in_data_a = 8'h11; in_data_b = 8'h22; in_data_c = 8'h33; in_data_d = 8'h44;
      in_valid = 4'b1111; out_ready = 1'b1;
      sb.push_back({2'd0, 8'h11}); sb.push_back({2'd1, 8'h22});
      sb.push_back({2'd2, 8'h33}); sb.push_back({2'd3, 8'h44});
      tick();
      in_valid = '0;
      wait_drain("all4_drain", 20);
      check("all4_count", hs_cyc.size(), 4);
      for (int i = 0; i + 1 < hs_cyc.size(); i++)
         check("all4_spacing", hs_cyc[i+1] - hs_cyc[i], SPACING);

      // 4: b granted with consumer stalled; a and d written during the stall
      tick();
      out_ready = 1'b0;
      in_data_b = 8'h66; in_valid = 4'b0010;
      sb.push_back({2'd1, 8'h66});
      tick();
      in_valid = '0;
      tick();
      in_data_b = 8'h99; in_data_a = 8'hA1; in_data_d = 8'hD4;
      in_valid = 4'b1011;
      sb.push_back({2'd3, 8'hD4});
      sb.push_back({2'd0, 8'hA1});
      for (int i = 0; i < 5; i++) begin
         tick();
         check("stall_out_valid", out_valid, 1'b1);
         check("stall_sel", {s1, s0}, 2'b01);
         check("stall_ch_b", ch_b, 8'h66);
         check("stall_in_ready", in_ready, 4'b0100);
      end
      check("stall_ch_a", ch_a, 8'hA1);
      check("stall_ch_d", ch_d, 8'hD4);

      // 5: release -> b, then d before a
      in_valid = '0; out_ready = 1'b1;
      wait_drain("rr_drain", 20);
      check("rr_in_ready", in_ready, 4'b1111);
      check("rr_ch_b_kept", ch_b, 8'h66);

      // 6: asynchronous reset while granting
      out_ready = 1'b0;
      in_data_a = 8'h77; in_valid = 4'b0001;
      tick();
      in_valid = '0;
      tick();
      check("arst_pre_valid", out_valid, 1'b1);
      #2 reset = 1'b1;
      #1;
      check("arst_out_valid", out_valid, 1'b0);
      check("arst_in_ready", in_ready, 4'b1111);
      check("arst_ch_a", ch_a, 8'h00);
      tick();
      reset = 1'b0;
      out_ready = 1'b1;
      tick(); tick();
      check("arst_stays_idle", out_valid, 1'b0);
      check("final_sb_empty", sb.size(), 0);

      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
